// File: rtl/clock_pkg.sv
// Shared constants for the clock datapath (second_count, minute_count, hour_count).
package clock_pkg;

    localparam int unsigned SEC_MAX  = 59;
    localparam int unsigned MIN_MAX  = 59;
    localparam int unsigned HOUR_MAX = 23;

    localparam int unsigned SEC_BIT  = 6;
    localparam int unsigned MIN_BIT  = 6;
    localparam int unsigned HOUR_BIT = 5;

    typedef logic [SEC_BIT-1:0]  sec_t;
    typedef logic [MIN_BIT-1:0]  min_t;
    typedef logic [HOUR_BIT-1:0] hour_t;

endpackage

// File: rtl/second_count_if.sv
// Control and status bundle between the clock controller and second_count.
interface second_count_if
    import clock_pkg::*;
#(
    parameter int unsigned P_SEC_BIT = SEC_BIT
);

    logic                 i_run;
    logic                 i_clear;
    logic [P_SEC_BIT-1:0] second;
    logic                 o_one_sec_tick;
    logic                 one_minute_tick;

    modport master (
        output i_run,
        output i_clear,
        input  second,
        input  o_one_sec_tick,
        input  one_minute_tick
    );

    modport slave (
        input  i_run,
        input  i_clear,
        output second,
        output o_one_sec_tick,
        output one_minute_tick
    );

endinterface

// File: rtl/second_count_tick_gen.sv
// Prescaler: emits a registered one-cycle tick once every P_CLK_DIV running cycles.
module tick_gen #(
    parameter int unsigned P_CLK_DIV = 100_000_000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_run,
    input  logic i_clear,
    output logic o_tick
);

    localparam int unsigned          P_DIV_BIT = (P_CLK_DIV > 2) ? $clog2(P_CLK_DIV) : 1;
    localparam logic [P_DIV_BIT-1:0] DIV_LAST  = P_DIV_BIT'(P_CLK_DIV - 1);

    logic [P_DIV_BIT-1:0] div_cnt;
    logic                 div_wrap;

    assign div_wrap = (div_cnt == DIV_LAST);

    // Prescaler count and registered tick; count holds while not running.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt <= '0;
            o_tick  <= 1'b0;
        end else if (i_clear) begin
            div_cnt <= '0;
            o_tick  <= 1'b0;
        end else begin
            o_tick <= i_run && div_wrap;
            if (i_run) begin
                div_cnt <= div_wrap ? '0 : div_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/second_count.sv
// Seconds stage: prescaled one-second tick plus a 0..59 counter and minute flag.
module second_count
    import clock_pkg::*;
#(
    parameter int unsigned P_CLK_DIV = 100_000_000,
    parameter int unsigned P_SEC_BIT = SEC_BIT
) (
    input  logic          clk,
    input  logic          reset_n,
    second_count_if.slave bus
);

    localparam logic [P_SEC_BIT-1:0] SEC_LAST = P_SEC_BIT'(SEC_MAX);

    logic                 tick;
    logic [P_SEC_BIT-1:0] sec_q;

    tick_gen #(
        .P_CLK_DIV(P_CLK_DIV)
    ) u_tick_gen (
        .clk    (clk),
        .reset_n(reset_n),
        .i_run  (bus.i_run),
        .i_clear(bus.i_clear),
        .o_tick (tick)
    );

    // Seconds advance on the visible tick, even if i_run has just dropped,
    // so a pending tick is never lost; clear suppresses that increment.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sec_q <= '0;
        end else if (bus.i_clear) begin
            sec_q <= '0;
        end else if (tick) begin
            sec_q <= (sec_q == SEC_LAST) ? '0 : sec_q + 1'b1;
        end
    end

    assign bus.second          = sec_q;
    assign bus.o_one_sec_tick  = tick;
    assign bus.one_minute_tick = (sec_q == SEC_LAST);

endmodule

// File: tb/tb_second_count.sv
// Scoreboarded bench for second_count with P_CLK_DIV=10.
module tb_second_count;
    import clock_pkg::*;

    localparam int unsigned CLK_DIV = 10;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    second_count_if #(.P_SEC_BIT(SEC_BIT)) bus ();

    second_count #(
        .P_CLK_DIV(CLK_DIV),
        .P_SEC_BIT(SEC_BIT)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int sec;
        int tick;
        int minute;
    } exp_t;

    exp_t exp_q[$];

    // Reference model: running cycles since last clear, and seconds as ticks mod 60.
    int m_runs = 0;
    int m_secs = 0;
    int m_tick = 0;

    function automatic void check(string name, int act, int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endfunction

    function automatic void model_reset();
        m_runs = 0;
        m_secs = 0;
        m_tick = 0;
        exp_q.delete();
    endfunction

    function automatic void model_step(input int run, input int clr);
        exp_t e;
        if (clr != 0) begin
            m_runs = 0;
            m_secs = 0;
            m_tick = 0;
        end else begin
            if (m_tick != 0) m_secs = (m_secs + 1) % 60;
            if (run != 0) begin
                m_runs++;
                m_tick = (m_runs % CLK_DIV == 0) ? 1 : 0;
            end else begin
                m_tick = 0;
            end
        end
        e.sec    = m_secs;
        e.tick   = m_tick;
        e.minute = (m_secs == 59) ? 1 : 0;
        exp_q.push_back(e);
    endfunction

    function automatic void sb_compare();
        exp_t e;
        e = exp_q.pop_front();
        check("sb_second", int'(bus.second), e.sec);
        check("sb_tick", int'(bus.o_one_sec_tick), e.tick);
        check("sb_minute", int'(bus.one_minute_tick), e.minute);
    endfunction

    // Model predicts post-edge outputs from the inputs present at each edge.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) model_reset();
        else model_step(int'(bus.i_run), int'(bus.i_clear));
    end

    // Monitor compares DUT outputs against the queue on the opposite edge.
    always @(negedge clk) begin
        if (reset_n && exp_q.size() != 0) sb_compare();
    end

    task automatic step(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_tick(input int max_cyc, output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!bus.o_one_sec_tick && n < max_cyc);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int sec0;
        int hi_cnt;
        int both_cnt;
        int bad_tick;
        int bad_sec;
        int prev;
        int ticks;
        int consec;

        bus.i_run   = 1'b0;
        bus.i_clear = 1'b0;
        step(3);
        check("reset_second", int'(bus.second), 0);
        check("reset_tick", int'(bus.o_one_sec_tick), 0);
        check("reset_minute", int'(bus.one_minute_tick), 0);

        // 1: first tick after 10 running cycles, one cycle wide
        reset_n   = 1'b1;
        bus.i_run = 1'b1;
        wait_tick(20, n);
        check("t1_first_tick_latency", n, 10);
        check("t1_second_at_tick", int'(bus.second), 0);
        step(1);
        check("t1_tick_width", int'(bus.o_one_sec_tick), 0);
        check("t1_second_after_tick", int'(bus.second), 1);
        wait_tick(20, n);
        check("t1_second_tick_latency", n, 9);

        // 2: one full minute from a clear
        bus.i_clear = 1'b1;
        step(1);
        bus.i_clear = 1'b0;
        hi_cnt   = 0;
        both_cnt = 0;
        for (int i = 0; i < 600; i++) begin
            step(1);
            if (bus.one_minute_tick) hi_cnt++;
            if (bus.one_minute_tick && bus.o_one_sec_tick) both_cnt++;
        end
        check("t2_minute_high_cycles", hi_cnt, 10);
        check("t2_minute_qualified", both_cnt, 1);
        check("t2_second_at_boundary", int'(bus.second), 59);
        step(1);
        check("t2_second_wrapped", int'(bus.second), 0);

        // 3: pause at div_cnt=4 for 25 cycles
        wait_tick(20, n);
        step(4);
        bus.i_run = 1'b0;
        sec0      = int'(bus.second);
        bad_tick  = 0;
        bad_sec   = 0;
        for (int i = 0; i < 25; i++) begin
            step(1);
            if (bus.o_one_sec_tick) bad_tick++;
            if (int'(bus.second) != sec0) bad_sec++;
        end
        check("t3_ticks_while_paused", bad_tick, 0);
        check("t3_second_changes_paused", bad_sec, 0);
        bus.i_run = 1'b1;
        wait_tick(20, n);
        check("t3_resume_latency", n, 6);

        // 4: clear on the tick cycle where second==59
        for (int i = 0; i < 70; i++) begin
            wait_tick(20, n);
            if (bus.second == 6'd59) break;
        end
        check("t4_reached_59", int'(bus.second), 59);
        check("t4_tick_at_59", int'(bus.o_one_sec_tick), 1);
        bus.i_clear = 1'b1;
        step(1);
        check("t4_second_cleared", int'(bus.second), 0);
        check("t4_tick_cleared", int'(bus.o_one_sec_tick), 0);
        bus.i_clear = 1'b0;
        wait_tick(20, n);
        check("t4_tick_after_clear", n, 10);

        // 5: asynchronous reset mid-cycle at second==37
        for (int i = 0; i < 700; i++) begin
            if (bus.second == 6'd37) break;
            step(1);
        end
        check("t5_reached_37", int'(bus.second), 37);
        step(3);
        #3;
        reset_n = 1'b0;
        #1;
        check("t5_async_second", int'(bus.second), 0);
        check("t5_async_tick", int'(bus.o_one_sec_tick), 0);
        check("t5_async_minute", int'(bus.one_minute_tick), 0);
        step(2);
        #2;
        reset_n = 1'b1;
        wait_tick(20, n);
        check("t5_tick_after_reset", n, 10);

        // 6: i_run toggled every cycle for 40 cycles
        bus.i_clear = 1'b1;
        step(1);
        bus.i_clear = 1'b0;
        ticks  = 0;
        consec = 0;
        prev   = 0;
        for (int i = 0; i < 40; i++) begin
            bus.i_run = (i % 2 == 0);
            step(1);
            if (bus.o_one_sec_tick) begin
                ticks++;
                if (prev != 0) consec++;
            end
            prev = int'(bus.o_one_sec_tick);
        end
        check("t6_tick_count", ticks, 2);
        check("t6_back_to_back", consec, 0);

        // Randomised run/clear traffic checked by the scoreboard
        for (int i = 0; i < 3000; i++) begin
            bus.i_run   = ($urandom_range(0, 9) < 7);
            bus.i_clear = ($urandom_range(0, 99) < 2);
            step(1);
        end
        bus.i_clear = 1'b0;
        bus.i_run   = 1'b0;
        step(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
